// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits are answered combinationally; misses refill one word over a req/valid handshake.
module icache #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        en_i,
  input  logic [31:0] addr_i,
  output logic        rdy_o,
  output logic [31:0] inst_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                 state_q;
  logic [Lines-1:0]       valid_q;
  logic [TagBits-1:0]     tag_arr  [Lines];
  logic [31:0]            data_arr [Lines];

  logic [INDEX_BITS-1:0]  idx;
  logic [TagBits-1:0]     tag;
  logic [INDEX_BITS-1:0]  fill_idx;
  logic                   lookup_hit;
  logic                   fill_we;

  assign idx      = addr_i[INDEX_BITS+1:2];
  assign tag      = addr_i[31:INDEX_BITS+2];
  // The outstanding miss address lives in mem_addr_o for the whole refill.
  assign fill_idx = mem_addr_o[INDEX_BITS+1:2];

  assign lookup_hit = en_i && valid_q[idx] && (tag_arr[idx] == tag);
  assign rdy_o      = lookup_hit && (state_q == StIdle);
  assign inst_o     = data_arr[idx];

  assign fill_we = !rst && rdy && (state_q == StWait) && mem_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
    end else if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (en_i && !lookup_hit) begin
            mem_en_o   <= 1'b1;
            mem_addr_o <= {addr_i[31:2], 2'b00};
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (mem_valid_i) begin
            valid_q[fill_idx] <= 1'b1;
            mem_en_o          <= 1'b0;
            state_q           <= StIdle;
          end
        end
      endcase
    end
  end

  // Tag/data storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[fill_idx]  <= mem_addr_o[31:INDEX_BITS+2];
      data_arr[fill_idx] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: hand-computed refill/hit sequences with a fixed-latency responder.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        en_i;
  logic [31:0] addr_i;
  logic        rdy_o;
  logic [31:0] inst_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  int total = 0;
  int bad   = 0;

  icache #(.INDEX_BITS(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .en_i       (en_i),
    .addr_i     (addr_i),
    .rdy_o      (rdy_o),
    .inst_o     (inst_o),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_valid_i(mem_valid_i),
    .mem_data_i (mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss on a, memory answers with d after lat idle waiting cycles, then check the hit.
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int lat);
    en_i   = 1'b1;
    addr_i = a;
    #1;
    check("fill_miss_rdy", {31'b0, rdy_o}, 32'h0);
    step();
    check("fill_req_en", {31'b0, mem_en_o}, 32'h1);
    check("fill_req_addr", mem_addr_o, {a[31:2], 2'b00});
    for (int i = 0; i < lat; i++) begin
      step();
      check("fill_hold_en", {31'b0, mem_en_o}, 32'h1);
      check("fill_wait_rdy", {31'b0, rdy_o}, 32'h0);
    end
    mem_valid_i = 1'b1;
    mem_data_i  = d;
    step();
    mem_valid_i = 1'b0;
    mem_data_i  = 32'h0;
    #1;
    check("fill_hit_rdy", {31'b0, rdy_o}, 32'h1);
    check("fill_hit_inst", inst_o, d);
    check("fill_done_en", {31'b0, mem_en_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; en_i = 1'b0; addr_i = 32'h0;
    mem_valid_i = 1'b0; mem_data_i = 32'h0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    en_i = 1'b1; addr_i = 32'h0;
    #1;
    check("rst_rdy", {31'b0, rdy_o}, 32'h0);
    check("rst_mem_en", {31'b0, mem_en_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);

    // 1. Cold miss: pulse on the third edge after mem_en_o rises
    fill(32'h0000_0000, 32'h0000_0093, 2);

    // 2. Sequential hits
    fill(32'h0000_0004, 32'h0000_0013, 1);
    fill(32'h0000_0008, 32'h0040_0113, 0);
    addr_i = 32'h0;
    #1;
    check("seq0_rdy", {31'b0, rdy_o}, 32'h1);
    check("seq0_inst", inst_o, 32'h0000_0093);
    step();
    addr_i = 32'h4;
    #1;
    check("seq1_rdy", {31'b0, rdy_o}, 32'h1);
    check("seq1_inst", inst_o, 32'h0000_0013);
    check("seq1_mem_en", {31'b0, mem_en_o}, 32'h0);
    step();
    addr_i = 32'hA;  // low bits ignored
    #1;
    check("seq2_rdy", {31'b0, rdy_o}, 32'h1);
    check("seq2_inst", inst_o, 32'h0040_0113);
    check("seq2_mem_en", {31'b0, mem_en_o}, 32'h0);
    en_i = 1'b0;
    #1;
    check("no_en_rdy", {31'b0, rdy_o}, 32'h0);
    step();
    check("no_en_mem_en", {31'b0, mem_en_o}, 32'h0);

    // 3. Conflict eviction: 0x10 and 0x210 share index 4
    fill(32'h0000_0010, 32'h0000_0111, 1);
    fill(32'h0000_0210, 32'h0000_0222, 1);
    fill(32'h0000_0010, 32'h0000_0333, 0);

    // 4. Redirect mid-miss to a cached line
    fill(32'h0000_0040, 32'h0000_0440, 0);
    addr_i = 32'h0000_0100;
    step();
    check("redir_req_addr", mem_addr_o, 32'h0000_0100);
    addr_i = 32'h0000_0040;
    #1;
    check("redir_wait_rdy", {31'b0, rdy_o}, 32'h0);
    step();
    check("redir_wait_rdy2", {31'b0, rdy_o}, 32'h0);
    mem_valid_i = 1'b1; mem_data_i = 32'h0000_1000;
    step();
    mem_valid_i = 1'b0; mem_data_i = 32'h0;
    #1;
    check("redir_hit_rdy", {31'b0, rdy_o}, 32'h1);
    check("redir_hit_inst", inst_o, 32'h0000_0440);
    addr_i = 32'h0000_0100;
    #1;
    check("redir_fill_rdy", {31'b0, rdy_o}, 32'h1);
    check("redir_fill_inst", inst_o, 32'h0000_1000);

    // 5. Reset mid-miss, then a stray valid pulse
    addr_i = 32'h0000_0380;
    step();
    check("rstm_req_en", {31'b0, mem_en_o}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; en_i = 1'b0;
    check("rstm_mem_en", {31'b0, mem_en_o}, 32'h0);
    check("rstm_mem_addr", mem_addr_o, 32'h0);
    mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    step();
    mem_valid_i = 1'b0; mem_data_i = 32'h0;
    check("stray_mem_en", {31'b0, mem_en_o}, 32'h0);
    en_i = 1'b1; addr_i = 32'h0;
    #1;
    check("stray_old0_rdy", {31'b0, rdy_o}, 32'h0);
    addr_i = 32'h0000_0040;
    #1;
    check("stray_old40_rdy", {31'b0, rdy_o}, 32'h0);
    fill(32'h0000_0380, 32'h0000_3803, 1);

    // 6. rdy stall in WAIT, with a pulse lost while stalled
    addr_i = 32'h0000_0500;
    step();
    check("stall_req_addr", mem_addr_o, 32'h0000_0500);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_valid_i = (i == 1);
      mem_data_i  = 32'h0000_0BAD;
      step();
      check("stall_hold_en", {31'b0, mem_en_o}, 32'h1);
      check("stall_hold_addr", mem_addr_o, 32'h0000_0500);
    end
    mem_valid_i = 1'b0; mem_data_i = 32'h0;
    rdy = 1'b1;
    #1;
    check("stall_wait_rdy", {31'b0, rdy_o}, 32'h0);
    step();
    check("stall_resume_en", {31'b0, mem_en_o}, 32'h1);
    mem_valid_i = 1'b1; mem_data_i = 32'h0000_5005;
    step();
    mem_valid_i = 1'b0; mem_data_i = 32'h0;
    #1;
    check("stall_hit_rdy", {31'b0, rdy_o}, 32'h1);
    check("stall_hit_inst", inst_o, 32'h0000_5005);
    check("stall_done_en", {31'b0, mem_en_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache. It is the responder to the fetch stage's cache request interface (en/addr in, rdy/inst out).
- Hits are served combinationally in the same cycle as the request.
- Misses are refilled one word at a time from the memory controller over a request/valid handshake.
- Sits between the fetch stage and the memory controller's instruction port.

Parameters:
INDEX_BITS, 7, number of index bits; cache holds 2^INDEX_BITS one-word lines (default 128 lines = 512 B).

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
rdy  input  1  global enable; when low, no state changes
en_i  input  1  fetch request valid
addr_i  input  32  fetch byte address; bits [1:0] ignored
rdy_o  output  1  inst_o holds the word at addr_i in this cycle
inst_o  output  32  instruction word
mem_en_o  output  1  refill request to memory controller (registered)
mem_addr_o  output  32  word-aligned refill address, bits [1:0]=0 (registered)
mem_valid_i  input  1  one-cycle pulse: refill data valid
mem_data_i  input  32  refill data

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
- Storage: valid bit, tag and data word per line.
- Hit = en_i && valid[index] && tag_arr[index]==tag.
- rdy_o = hit && state==IDLE, combinational from addr_i.
- inst_o = data_arr[index] (combinational); it is only meaningful when rdy_o=1.
- rdy_o must never be high for a word other than the one at the current addr_i. The fetch stage changes addr_i every cycle and depends on this.
- No fill bypass: the returned word becomes visible as a hit in the cycle after the mem_valid_i edge.
- FSM states: IDLE, WAIT.
  - IDLE, rdy=1, en_i=1, miss:
    - latch miss_addr = {addr_i[31:2],2'b00}
    - mem_en_o<=1, mem_addr_o<=miss_addr
    - go to WAIT
  - IDLE, hit or en_i=0: stay in IDLE; mem_en_o stays 0.
  - WAIT:
    - hold mem_en_o=1 and mem_addr_o stable until mem_valid_i.
    - rdy_o=0 regardless of addr_i, including hits on other lines.
  - WAIT with mem_valid_i=1:
    - write data_arr, tag_arr and valid for miss_addr's index.
    - mem_en_o<=0, go to IDLE.
- Memory handshake contract:
  - The controller samples a request while mem_en_o=1 and answers with exactly one mem_valid_i pulse.
  - Because mem_en_o drops on the same edge that consumes mem_valid_i, the controller must not start a second request in the cycle after the pulse.
- Redirect during miss: if addr_i changes while in WAIT, the refill still completes and writes its line. After returning to IDLE, the new addr_i is evaluated normally and may trigger a new miss.
- Replacement: a fill overwrites whatever was in that line, with no write-back (read-only cache).
- mem_valid_i while in IDLE is ignored: no array write, no state change.
- rdy=0: FSM, arrays, mem_en_o and mem_addr_o all hold. rdy_o/inst_o still evaluate combinationally. A mem_valid_i arriving while rdy=0 is lost, so the controller must gate on the same rdy.
- Reset (including mid-miss):
  - state=IDLE
  - all valid bits cleared
  - mem_en_o=0, mem_addr_o=0
  - rdy_o=0 after reset until a line is filled
  - tag and data arrays need not be reset
- Latency:
  - hit: 0 cycles
  - miss: 1 cycle to issue the request, plus memory latency, plus 1 cycle before the hit is visible

Test Plan:
1. Cold miss:
   - Stimulus: after rst, en_i=1, addr_i=0x0000_0000; memory returns 0x0000_0093 three cycles after mem_en_o rises.
   - Required: mem_en_o=1 with mem_addr_o=0 one edge after the request, held until the pulse; rdy_o=1 with inst_o=0x0000_0093 in the cycle after the pulse.
2. Sequential hits:
   - Stimulus: prefill 0x0,0x4,0x8, then step addr_i 0x0→0x4→0x8 on consecutive cycles.
   - Required: rdy_o=1 every cycle with matching data; mem_en_o stays 0.
3. Conflict eviction:
   - Stimulus: fill 0x0000_0010, then request 0x0000_0210, which has the same index and a different tag.
   - Required: miss, then refill from 0x210; a later request to 0x10 misses again.
4. Redirect mid-miss:
   - Stimulus: miss on 0x100; while in WAIT, addr_i changes to 0x40, which is already cached.
   - Required: rdy_o=0 until the fill completes, and 0x100's line is written; next cycle rdy_o=1 for 0x40.
5. Reset mid-miss and stray valid:
   - Stimulus: assert rst in WAIT; afterwards pulse mem_valid_i with 0xDEAD_BEEF.
   - Required: mem_en_o=0, no line valid, and a request to the old address misses.
6. rdy stall:
   - Stimulus: drop rdy for 3 cycles while in WAIT.
   - Required: mem_en_o/mem_addr_o held and state unchanged; the fill completes normally after rdy returns.
